distribute_1xn_buf: RTL
=======================

# distribute_1xN_buf

Parametrised 1-to-N multicast distribute switch with a registered holding stage and valid/ready flow control on every port. It is the next generation of the 1x2 sequential distribute micro-switch. It widens fan-out to NUM_OUT branches, takes a per-branch destination bitmask as its command, and holds a word until every targeted branch has accepted it, so independent downstream stalls cannot lose or duplicate data. It sits at the fan-out points of the accelerator NoC distribution tree, between buffered links.

## Interface
- NUM_OUT, 4: number of output branches (≥2).
- DATA_WIDTH, 32: payload width per branch.
- COMMAND_WIDTH, NUM_OUT: destination mask width; must equal NUM_OUT.
- DROP_CNT_WIDTH, 16: width of the zero-mask drop counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  input word valid.
- i_ready  out  1  switch can accept this cycle.
- i_data_bus  in  DATA_WIDTH  input payload.
- i_cmd  in  COMMAND_WIDTH  destination mask; bit k targets branch k; sampled with i_data_bus.
- i_en  in  1  acceptance enable; low blocks new acceptance only.
- o_valid  out  NUM_OUT  per-branch valid.
- o_ready  in  NUM_OUT  per-branch downstream ready.
- o_data_bus  out  NUM_OUT*DATA_WIDTH  branch k at [k*DATA_WIDTH +: DATA_WIDTH].
- o_busy  out  1  holding stage has undelivered branches.
- o_drop_cnt  out  DROP_CNT_WIDTH  saturating count of accepted zero-mask words.

## Operation
- State: data_q (DATA_WIDTH), pend_q (NUM_OUT mask), drop_q (DROP_CNT_WIDTH).
- o_valid = pend_q. Branch k data = data_q when pend_q[k], else all-zero dummy data.
- o_busy = |pend_q.
- Branch k delivers when o_valid[k] & o_ready[k]; that cycle clears pend_q[k].
- pend_next = pend_q & ~o_ready.
- i_ready = i_en & (pend_next == 0). The holding stage frees in the same cycle as the last pending delivery, which gives full back-to-back throughput.
- Accept = i_valid & i_ready. On accept, data_q <= i_data_bus and pend_q <= i_cmd. Otherwise pend_q <= pend_next and data_q holds.
- Zero-mask accept (i_cmd == 0):
  - pend_q stays 0.
  - data_q still loads.
  - drop_q increments and saturates at all-ones.
- Valid stability: once pend_q[k] sets, o_valid[k] and branch k data stay constant until delivered. i_en low does not retract outputs; in-flight deliveries still complete.
- Multicast branches complete independently in any order. The word is retired only when all targeted bits have cleared.
- Unicast (one-hot) and broadcast (all ones) are special cases; no separate mode.

## Timing
- Latency: a word accepted at edge t is presented on its targeted branches in the cycle after t, so the minimum input-to-output latency is 1 cycle.
- Throughput: 1 word/cycle when all targeted o_ready are high.
- Combinational path o_ready -> i_ready exists. No path exists from i_valid to any output.
- Reset (asynchronous assert, any cycle including mid-multicast):
  - pend_q = 0, data_q = 0, drop_q = 0.
  - Resulting outputs: o_valid = 0, o_data_bus = 0, o_busy = 0, o_drop_cnt = 0.
  - i_ready = 0 while rst is high.
  - Partially delivered words are discarded.
- Release: first acceptance is possible in the first cycle with rst low and i_en high.
- Simultaneous events:
  - The final delivery and a new accept in the same cycle: pend_q takes i_cmd, not 0.
  - Deliveries on several branches in one cycle clear all corresponding bits.
- i_en low with pend_q == 0: i_ready = 0 and state holds.

## Structure
- Shared package noc_switch_pkg holds:
  - the dummy-data constant (all zeros);
  - a function returning the cmd mask for the unicast/broadcast encodings;
  - the legacy 2-bit encodings: 01 low, 10 high, 11 duplicate.
- No sub-module is required. The per-branch output logic is a generate loop inside the block.

## Test plan
- Unicast, NUM_OUT=4, all o_ready=1: i_cmd=4'b0100, data 32'hA5A5_0001 -> next cycle o_valid=4'b0100, branch 2 = A5A5_0001, other branches 0, i_ready stays 1.
- Broadcast with stagger: i_cmd=4'b1111, data 32'h0000_BEEF; o_ready held at 4'b0011 for 3 cycles, then 4'b1111 -> bits 0 and 1 clear after the first cycle; i_ready=0 until the cycle where o_ready=1111; exactly one beat per branch.
- Back-to-back streaming: 8 words with alternating masks 4'b0001 and 4'b1000, all ready -> 8 consecutive accepts, each word on the correct branch exactly once.
- Zero mask: 3 accepts with i_cmd=0 -> o_valid never asserts, o_drop_cnt=3. With DROP_CNT_WIDTH=2, 5 accepts -> o_drop_cnt saturates at 3.
- i_en low mid-multicast: pend 4'b0110, i_en=0, o_ready=4'b0110 -> delivery completes, pend=0, i_ready stays 0 until i_en=1.
- Async reset mid-multicast: pend 4'b1010, assert rst between edges -> o_valid=0 and o_data_bus=0 immediately; after release, no stale beat appears.

Source files
------------

// File: rtl/noc_switch_pkg.sv
// Shared definitions for the NoC distribution switches: dummy payload,
// destination-mask helpers and the legacy 1x2 command encodings.
package noc_switch_pkg;

    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_OUT        = 32;

    // Driven on branches that have nothing pending so idle lanes stay quiet.
    localparam logic [MAX_DATA_WIDTH-1:0] DUMMY_DATA = '0;

    typedef enum logic [1:0] {
        LEGACY_LOW  = 2'b01,
        LEGACY_HIGH = 2'b10,
        LEGACY_DUP  = 2'b11
    } legacy_cmd_e;

    typedef enum logic {
        CMD_UNICAST   = 1'b0,
        CMD_BROADCAST = 1'b1
    } cmd_kind_e;

    function automatic logic [MAX_OUT-1:0] cmd_mask(input cmd_kind_e kind,
                                                    input int unsigned dest,
                                                    input int unsigned num_out);
        logic [MAX_OUT:0]   ones;
        logic [MAX_OUT-1:0] one_hot;
        ones    = ({{MAX_OUT{1'b0}}, 1'b1} << num_out) - {{MAX_OUT{1'b0}}, 1'b1};
        one_hot = {{(MAX_OUT-1){1'b0}}, 1'b1} << dest;
        return (kind == CMD_BROADCAST) ? ones[MAX_OUT-1:0] : one_hot;
    endfunction

    // Legacy encodings already are masks: bit 0 low branch, bit 1 high branch.
    function automatic logic [1:0] legacy_mask(input legacy_cmd_e enc);
        return enc;
    endfunction

endpackage

// File: rtl/distribute_1xn_buf_if.sv
// Handshake bundle for the 1xN distribute switch: one upstream port and
// NUM_OUT downstream branches flattened into vectors.
interface distribute_1xn_buf_if #(
    parameter int NUM_OUT        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int DROP_CNT_WIDTH = 16
);
    logic                          i_valid;
    logic                          i_ready;
    logic [DATA_WIDTH-1:0]         i_data_bus;
    logic [NUM_OUT-1:0]            i_cmd;
    logic                          i_en;
    logic [NUM_OUT-1:0]            o_valid;
    logic [NUM_OUT-1:0]            o_ready;
    logic [NUM_OUT*DATA_WIDTH-1:0] o_data_bus;
    logic                          o_busy;
    logic [DROP_CNT_WIDTH-1:0]     o_drop_cnt;

    modport master (
        output i_valid, i_data_bus, i_cmd, i_en, o_ready,
        input  i_ready, o_valid, o_data_bus, o_busy, o_drop_cnt
    );

    modport slave (
        input  i_valid, i_data_bus, i_cmd, i_en, o_ready,
        output i_ready, o_valid, o_data_bus, o_busy, o_drop_cnt
    );
endinterface

// File: rtl/distribute_1xn_buf.sv
// 1-to-N multicast distribute switch: a single holding register keeps a word
// until every branch named in its destination mask has taken it.
module distribute_1xn_buf
    import noc_switch_pkg::*;
#(
    parameter int NUM_OUT        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int COMMAND_WIDTH  = NUM_OUT,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    distribute_1xn_buf_if.slave      bus
);

    if (COMMAND_WIDTH != NUM_OUT) begin : g_bad_cmd_width
        $error("COMMAND_WIDTH must equal NUM_OUT");
    end
    if (NUM_OUT < 2 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_shape
        $error("unsupported NUM_OUT or DATA_WIDTH");
    end

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_CNT_WIDTH'(1);
    endfunction

    logic [DATA_WIDTH-1:0]     data_q;
    logic [NUM_OUT-1:0]        pend_q;
    logic [DROP_CNT_WIDTH-1:0] drop_q;
    logic [NUM_OUT-1:0]        pend_next;
    logic                      accept;

    // A branch retires its bit the cycle it hands off, so the stage can
    // reload in the same cycle as the last pending delivery.
    assign pend_next   = pend_q & ~bus.o_ready;
    assign bus.i_ready = bus.i_en & ~rst & (pend_next == '0);
    assign accept      = bus.i_valid & bus.i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            pend_q <= '0;
            drop_q <= '0;
        end else if (accept) begin
            data_q <= bus.i_data_bus;
            pend_q <= bus.i_cmd;
            if (bus.i_cmd == '0) begin
                drop_q <= sat_inc(drop_q);
            end
        end else begin
            pend_q <= pend_next;
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_branch
        assign bus.o_data_bus[k*DATA_WIDTH +: DATA_WIDTH] =
            pend_q[k] ? data_q : DUMMY_DATA[DATA_WIDTH-1:0];
    end

    assign bus.o_valid    = pend_q;
    assign bus.o_busy     = |pend_q;
    assign bus.o_drop_cnt = drop_q;

endmodule
